// File: rtl/reg_mux.sv
// N-way, WIDTH-bit registered selector with a 2-entry skid buffer and valid/ready handshake.
// Optional macro REG_MUX_SEL_CHECK_EN carries an out-of-range-select flag with each beat onto sel_err.
module reg_mux #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH*N_IN-1:0] in_put,
  input  logic [SEL_W-1:0]      select,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_put,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

  occ_e             state;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] or_data;
  logic [WIDTH-1:0] sk_data;
  logic             accept;
  logic             emit;
  logic             or_load_in;
  logic             or_load_sk;
  logic             sk_load;

  // Out-of-range selects fall through the loop and leave the data at zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (select == SEL_W'(k)) sel_data = in_put[k*WIDTH +: WIDTH];
    end
  end

  assign accept     = in_valid && in_ready;
  assign emit       = out_valid && out_ready;
  assign or_load_in = accept && ((state == EMPTY) || (state == ONE && emit));
  assign sk_load    = accept && (state == ONE) && !emit;
  assign or_load_sk = (state == FULL) && emit;

  // NOTE: in_ready and out_valid are flops updated with the state, so neither has a
  // combinational path from out_ready or in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          state     <= ONE;
          out_valid <= 1'b1;
        end
        ONE: begin
          if (accept && !emit) begin
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (!accept && emit) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: if (emit) begin
          state    <= ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the skid data register has no reset; it is only read after the FSM marks it full.
  always_ff @(posedge clk) begin
    if (sk_load) sk_data <= sel_data;
  end

  always_ff @(posedge clk) begin
    if (reset)           or_data <= '0;
    else if (or_load_in) or_data <= sel_data;
    else if (or_load_sk) or_data <= sk_data;
  end

  assign out_put = or_data;

`ifdef REG_MUX_SEL_CHECK_EN
  logic sel_oor;
  logic or_err;
  logic sk_err;

  always_comb begin
    sel_oor = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (select == SEL_W'(k)) sel_oor = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      or_err <= 1'b0;
      sk_err <= 1'b0;
    end else begin
      if (sk_load)         sk_err <= sel_oor;
      if (or_load_in)      or_err <= sel_oor;
      else if (or_load_sk) or_err <= sk_err;
    end
  end

  assign sel_err = out_valid && or_err;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_mux.sv
// Directed, table-driven bench for reg_mux: a 4-input instance for handshake/ordering
// vectors and a 3-input instance for out-of-range select behaviour.
module tb_reg_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 4-input instance
  logic [127:0] a_in;
  logic [1:0]   a_sel;
  logic         a_iv, a_ir, a_ov, a_ordy, a_err;
  logic [31:0]  a_out;

  // 3-input instance
  logic [95:0]  b_in;
  logic [1:0]   b_sel;
  logic         b_iv, b_ir, b_ov, b_ordy, b_err;
  logic [31:0]  b_out;

  int checks = 0;
  int errors = 0;

`ifdef REG_MUX_SEL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  reg_mux #(.WIDTH(32), .N_IN(4), .SEL_W(2)) dut_a (
    .clk(clk), .reset(reset), .in_put(a_in), .select(a_sel), .in_valid(a_iv),
    .in_ready(a_ir), .out_put(a_out), .out_valid(a_ov), .out_ready(a_ordy), .sel_err(a_err)
  );

  reg_mux #(.WIDTH(32), .N_IN(3), .SEL_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_put(b_in), .select(b_sel), .in_valid(b_iv),
    .in_ready(b_ir), .out_put(b_out), .out_valid(b_ov), .out_ready(b_ordy), .sel_err(b_err)
  );

  typedef struct packed {
    logic         iv;
    logic [1:0]   sel;
    logic [127:0] inp;
    logic         ordy;
    logic         exp_ov;
    logic [31:0]  exp_out;
    logic         exp_ir;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [127:0] lanes4(input logic [31:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {iv, sel, in_put, out_ready, exp out_valid, exp out_put, exp in_ready}
    vecs[0]  = '{1'b1, 2'd0, lanes4(67, 0, 0, 0),      1'b1, 1'b1, 32'd67, 1'b1};
    vecs[1]  = '{1'b0, 2'd0, lanes4(67, 0, 0, 0),      1'b1, 1'b0, 32'd0,  1'b1};
    vecs[2]  = '{1'b1, 2'd0, lanes4(10, 20, 30, 40),   1'b1, 1'b1, 32'd10, 1'b1};
    vecs[3]  = '{1'b1, 2'd1, lanes4(10, 20, 30, 40),   1'b1, 1'b1, 32'd20, 1'b1};
    vecs[4]  = '{1'b1, 2'd2, lanes4(10, 20, 30, 40),   1'b1, 1'b1, 32'd30, 1'b1};
    vecs[5]  = '{1'b1, 2'd3, lanes4(10, 20, 30, 40),   1'b1, 1'b1, 32'd40, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, lanes4(10, 20, 30, 40),   1'b1, 1'b0, 32'd0,  1'b1};
    vecs[7]  = '{1'b1, 2'd0, lanes4(5, 0, 0, 0),       1'b0, 1'b1, 32'd5,  1'b1};
    vecs[8]  = '{1'b1, 2'd0, lanes4(6, 0, 0, 0),       1'b0, 1'b1, 32'd5,  1'b0};
    vecs[9]  = '{1'b1, 2'd0, lanes4(7, 0, 0, 0),       1'b0, 1'b1, 32'd5,  1'b0};
    vecs[10] = '{1'b1, 2'd0, lanes4(7, 0, 0, 0),       1'b1, 1'b1, 32'd6,  1'b1};
    vecs[11] = '{1'b1, 2'd0, lanes4(7, 0, 0, 0),       1'b1, 1'b1, 32'd7,  1'b1};
    vecs[12] = '{1'b0, 2'd0, lanes4(7, 0, 0, 0),       1'b1, 1'b0, 32'd0,  1'b1};
    vecs[13] = '{1'b1, 2'd1, lanes4(0, 99, 55, 0),     1'b0, 1'b1, 32'd99, 1'b1};
    vecs[14] = '{1'b0, 2'd2, lanes4(0, 99, 55, 0),     1'b0, 1'b1, 32'd99, 1'b1};
    vecs[15] = '{1'b0, 2'd2, lanes4(0, 99, 55, 0),     1'b1, 1'b0, 32'd0,  1'b1};

    reset = 1'b1;
    a_in = '0; a_sel = '0; a_iv = 1'b0; a_ordy = 1'b0;
    b_in = '0; b_sel = '0; b_iv = 1'b0; b_ordy = 1'b0;
    step();
    step();
    check("rst_a_out_valid", 32'(a_ov), 32'd0);
    check("rst_a_out_put",   a_out,     32'd0);
    check("rst_a_sel_err",   32'(a_err), 32'd0);
    check("rst_b_out_valid", 32'(b_ov), 32'd0);
    check("rst_b_sel_err",   32'(b_err), 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_a_in_ready", 32'(a_ir), 32'd1);
    check("post_rst_b_in_ready", 32'(b_ir), 32'd1);

    // Table: single beat, streaming, backpressure, select change while stalled
    for (int i = 0; i < 16; i++) begin
      a_iv = vecs[i].iv; a_sel = vecs[i].sel; a_in = vecs[i].inp; a_ordy = vecs[i].ordy;
      step();
      check($sformatf("vec%0d_out_valid", i), 32'(a_ov), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d_in_ready", i),  32'(a_ir), 32'(vecs[i].exp_ir));
      if (vecs[i].exp_ov) check($sformatf("vec%0d_out_put", i), a_out, vecs[i].exp_out);
      check($sformatf("vec%0d_sel_err", i), 32'(a_err), 32'd0);
    end
    a_iv = 1'b0;

    // Out-of-range select on the 3-input instance, streaming
    b_in = {32'd33, 32'd22, 32'd11}; b_ordy = 1'b1;
    b_iv = 1'b1; b_sel = 2'd3;
    step();
    check("oor_out_valid", 32'(b_ov), 32'd1);
    check("oor_out_put",   b_out,     32'd0);
    check("oor_sel_err",   32'(b_err), 32'(EXP_ERR));
    b_sel = 2'd1;
    step();
    check("oor_next_out_put", b_out,      32'd22);
    check("oor_next_sel_err", 32'(b_err), 32'd0);
    b_iv = 1'b0;
    step();
    check("oor_idle_out_valid", 32'(b_ov),  32'd0);
    check("oor_idle_sel_err",   32'(b_err), 32'd0);

    // Out-of-range flag travelling behind a skid-held beat
    b_ordy = 1'b0; b_iv = 1'b1; b_sel = 2'd3;
    step();
    check("oor_bp1_sel_err", 32'(b_err), 32'(EXP_ERR));
    check("oor_bp1_out_put", b_out,      32'd0);
    b_sel = 2'd2;
    step();
    check("oor_bp2_in_ready", 32'(b_ir),  32'd0);
    check("oor_bp2_sel_err",  32'(b_err), 32'(EXP_ERR));
    b_iv = 1'b0; b_ordy = 1'b1;
    step();
    check("oor_bp3_out_put",  b_out,      32'd33);
    check("oor_bp3_sel_err",  32'(b_err), 32'd0);
    check("oor_bp3_in_ready", 32'(b_ir),  32'd1);
    step();
    check("oor_bp4_out_valid", 32'(b_ov), 32'd0);

    // Reset while FULL discards both beats
    a_ordy = 1'b0; a_iv = 1'b1; a_sel = 2'd0; a_in = lanes4(1, 2, 3, 4);
    step();
    step();
    check("mid_full_in_ready", 32'(a_ir), 32'd0);
    reset = 1'b1;
    step();
    check("mid_rst_out_valid", 32'(a_ov), 32'd0);
    check("mid_rst_in_ready",  32'(a_ir), 32'd1);
    check("mid_rst_out_put",   a_out,     32'd0);
    reset = 1'b0; a_iv = 1'b0; a_ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mid_rst_no_stale%0d", i), 32'(a_ov), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_mux.md
Name: reg_mux

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered output stage and a valid/ready handshake.
- Generalises the combinational 2:1 32-bit datapath mux to arbitrary width and input count.
- A 2-entry skid buffer absorbs backpressure without combinational ready paths.
- Sits between MIPS pipeline stages, for example ALU-operand or writeback-source selection, where the downstream stage may stall.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must be at least clog2(N_IN).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_put  input  WIDTH*N_IN  flat-packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- select  input  SEL_W  index of the input to forward; sampled with the beat.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- out_put  output  WIDTH  registered selected data.
- out_valid  output  1  out_put holds a valid beat.
- out_ready  input  1  downstream accepts the beat this cycle.
- sel_err  output  1  current out_put beat had an out-of-range select (see Optional Feature).

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset:
  - out_valid=0, skid empty, out_put=0, sel_err=0.
  - in_ready=1 in the first cycle after reset deasserts.
- Reset asserted mid-operation discards both held beats on that edge; there is no partial output.
- Accept: a beat transfers on any edge where in_valid && in_ready.
- Select sampling: select and in_put are captured on the accept edge only. Later changes to select do not alter a held beat.
- Emit: a beat transfers on any edge where out_valid && out_ready.
- Latency: an accepted beat appears on out_put/out_valid 1 cycle later when the output register is empty or draining.
- Storage: output register (OR) and skid register (SK). Occupancy is 0, 1 or 2.
- in_ready = !SK_full. It is registered and does not depend combinationally on out_ready.
- States and transitions (occ = occupancy):
  - EMPTY (occ 0): accept -> load OR -> ONE.
  - ONE (occ 1):
    - accept and emit -> OR reloaded, stay ONE.
    - accept, no emit -> beat goes into SK -> FULL.
    - emit, no accept -> EMPTY.
  - FULL (occ 2), in_ready=0:
    - emit -> SK moves to OR -> ONE.
    - in_valid is ignored while in FULL.
- Order is strictly preserved. There is no beat loss or duplication.
- Simultaneous accept and emit in ONE gives full throughput (1 beat/cycle).
- Selected value is in_put[select*WIDTH +: WIDTH] when select < N_IN.
- Out-of-range select (select >= N_IN): the data for the beat is 32'h0 (zero-width-extended to WIDTH).
- When out_valid=0, out_put holds its last value. Verification must not check out_put while out_valid=0.

Optional Feature:
- Macro: REG_MUX_SEL_CHECK_EN.
- Defined:
  - The out-of-range flag is captured with each beat and travels through SK/OR alongside the data.
  - sel_err equals the flag of the beat currently in OR, qualified by out_valid (sel_err=0 when out_valid=0).
- Undefined:
  - No flag storage is built; sel_err is tied 0.
  - Out-of-range data is still forced to 0.

Test Plan:
- Reset then single beat: in_put0=67, in_put1=0, select=0, in_valid=1 for one cycle, out_ready=1 -> next cycle out_put=67, out_valid=1; the cycle after that out_valid=0.
- Streaming: select cycles 0,1,2,3 with inputs 10,20,30,40 over 4 consecutive cycles, out_ready=1 -> out_put=10,20,30,40 on 4 consecutive cycles, in_ready=1 throughout.
- Backpressure:
  - out_ready=0 while sending beats 5 then 6 -> in_ready drops to 0 after the 2nd accept.
  - A 3rd beat (7) held with in_valid=1 is not taken.
  - Raising out_ready -> outputs 5, 6, 7 in order with no loss.
- Select change after accept: accept with select=1 (value 99), then change select to 2 while stalled -> emitted beat is still 99.
- Out-of-range: N_IN=3, select=3 -> out_put=0; with REG_MUX_SEL_CHECK_EN, sel_err=1 for that beat only and 0 for the next valid beat.
- Reset mid-operation: FULL with out_ready=0, assert reset for 1 cycle -> out_valid=0, in_ready=1, no stale beat emitted afterward.
